fruit_spawner: RTL and testbench

//   Multi-slot successor to the single-fruit placer. Holds up to NUM_FRUITS fruit positions (board cells).
//   On request it refills one slot with a free cell. The cell must not be snake body (occupancy RAM lookup),
//   the latched head, or another valid fruit. It is the farthest legal cell (Manhattan) from the head among

---
 rtl/snake_grid_pkg.sv | 35 +++
 rtl/lfsr16.sv | 19 +
 rtl/fruit_spawner.sv | 234 +++++++++++++++++++++++
 tb/tb_fruit_spawner.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_grid_pkg.sv
// Shared board geometry for the snake game: cell counts, playable window
// bounds, spawner FSM states and a small absolute-difference helper.
package snake_grid_pkg;

    localparam int H_CELLS      = 40;
    localparam int V_CELLS      = 30;
    localparam int MARGIN_CELLS = 1;
    localparam int CX_W         = 6;
    localparam int CY_W         = 5;

    localparam int X_MIN  = MARGIN_CELLS;
    localparam int X_MAX  = H_CELLS - 1 - MARGIN_CELLS;
    localparam int Y_MIN  = MARGIN_CELLS;
    localparam int Y_MAX  = V_CELLS - 1 - MARGIN_CELLS;
    localparam int X_SPAN = X_MAX - X_MIN + 1;
    localparam int Y_SPAN = Y_MAX - Y_MIN + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_DRAIN,
        S_SCAN,
        S_SCAN_DRAIN,
        S_DONE
    } spawn_state_t;

    // |a-b| by compare/subtract; y coordinates are zero-extended to CX_W.
    function automatic logic [CX_W-1:0] abs_diff(
        input logic [CX_W-1:0] a,
        input logic [CX_W-1:0] b
    );
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit maximal-length Fibonacci LFSR (x^16+x^14+x^13+x^11+1).
// Ports: clk, resetn (async, active low), rnd (current state, never zero).
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        resetn,
    output logic [15:0] rnd
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rnd <= SEED;
        end else begin
            rnd <= {rnd[14:0], rnd[15] ^ rnd[13] ^ rnd[12] ^ rnd[10]};
        end
    end

endmodule

// File: rtl/fruit_spawner.sv
// Multi-slot fruit placer: refills one slot with the free cell farthest from
// the latched head among TRIES random candidates, else the first free cell of
// a raster scan, else reports fail.
// Ports: req_valid/req_slot/req_ready + head_x/y (refill request),
//   eat_valid/eat_slot (invalidate slot), occ_rd_* (1-cycle occupancy RAM),
//   fruit_*_flat/fruit_valid (slot regfile), done/done_slot/fail (result).
module fruit_spawner
    import snake_grid_pkg::*;
#(
    parameter int NUM_FRUITS = 4,
    parameter int TRIES      = 16,
    parameter int MIN_DIST   = 3,
    localparam int SW        = (NUM_FRUITS > 1) ? $clog2(NUM_FRUITS) : 1
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       req_valid,
    input  logic [SW-1:0]              req_slot,
    output logic                       req_ready,
    input  logic [CX_W-1:0]            head_x,
    input  logic [CY_W-1:0]            head_y,
    input  logic                       eat_valid,
    input  logic [SW-1:0]              eat_slot,
    output logic                       occ_rd_en,
    output logic [CX_W-1:0]            occ_rd_x,
    output logic [CY_W-1:0]            occ_rd_y,
    input  logic                       occ_rd_data,
    output logic [NUM_FRUITS*CX_W-1:0] fruit_x_flat,
    output logic [NUM_FRUITS*CY_W-1:0] fruit_y_flat,
    output logic [NUM_FRUITS-1:0]      fruit_valid,
    output logic                       done,
    output logic [SW-1:0]              done_slot,
    output logic                       fail
);

    localparam logic [CX_W-1:0] XMIN    = CX_W'(X_MIN);
    localparam logic [CX_W-1:0] XMAX    = CX_W'(X_MAX);
    localparam logic [CY_W-1:0] YMIN    = CY_W'(Y_MIN);
    localparam logic [CY_W-1:0] YMAX    = CY_W'(Y_MAX);
    localparam logic [CX_W:0]   XSPAN   = (CX_W+1)'(X_SPAN);
    localparam logic [CY_W:0]   YSPAN   = (CY_W+1)'(Y_SPAN);
    localparam logic [CX_W:0]   MIND    = (CX_W+1)'(MIN_DIST);
    localparam logic [7:0]      TRIES_C = 8'(TRIES);

    spawn_state_t state;

    logic [15:0]     rnd;
    logic            unused_rnd;
    logic [SW-1:0]   slot_q;
    logic [CX_W-1:0] head_x_q;
    logic [CY_W-1:0] head_y_q;
    logic [7:0]      tries_left;
    logic [CX_W-1:0] scan_x;
    logic [CY_W-1:0] scan_y;

    logic            s1_valid;
    logic            s1_inrange;
    logic [CX_W-1:0] s1_x;
    logic [CY_W-1:0] s1_y;
    logic [CX_W:0]   s1_dist;

    logic [CX_W-1:0] best_x;
    logic [CY_W-1:0] best_y;
    logic [CX_W:0]   best_dist;
    logic            found;

    logic [CX_W-1:0] rx;
    logic [CY_W-1:0] ry;
    logic            rnd_inrange;
    logic [CX_W-1:0] issue_x;
    logic [CY_W-1:0] issue_y;
    logic [CX_W:0]   issue_dist;
    logic            scan_last;
    logic            s1_fruit_hit;
    logic            s1_head_hit;
    logic            s1_free;
    logic            s1_better;

    lfsr16 u_lfsr (
        .clk    (clk),
        .resetn (resetn),
        .rnd    (rnd)
    );

    assign unused_rnd = ^rnd[15:CX_W+CY_W];

    assign rx          = rnd[CX_W-1:0];
    assign ry          = rnd[CX_W+CY_W-1:CX_W];
    assign rnd_inrange = ({1'b0, rx} < XSPAN) && ({1'b0, ry} < YSPAN);

    assign req_ready = (state == S_IDLE);
    assign occ_rd_en = (state == S_SAMPLE) || (state == S_SCAN);
    assign issue_x   = (state == S_SCAN) ? scan_x : (XMIN + rx);
    assign issue_y   = (state == S_SCAN) ? scan_y : (YMIN + ry);
    assign occ_rd_x  = issue_x;
    assign occ_rd_y  = issue_y;

    assign issue_dist = {1'b0, abs_diff(issue_x, head_x_q)}
                      + {1'b0, abs_diff(CX_W'(issue_y), CX_W'(head_y_q))};

    assign scan_last = (scan_x == XMAX) && (scan_y == YMAX);

    // Only other live slots block a cell; the slot being refilled never does.
    always_comb begin
        s1_fruit_hit = 1'b0;
        for (int i = 0; i < NUM_FRUITS; i++) begin
            if (fruit_valid[i] && (SW'(i) != slot_q)
                && (fruit_x_flat[i*CX_W +: CX_W] == s1_x)
                && (fruit_y_flat[i*CY_W +: CY_W] == s1_y)) begin
                s1_fruit_hit = 1'b1;
            end
        end
    end

    assign s1_head_hit = (s1_x == head_x_q) && (s1_y == head_y_q);
    assign s1_free     = s1_valid && s1_inrange && !occ_rd_data
                       && !s1_head_hit && !s1_fruit_hit;
    // >= makes ties go to the later candidate.
    assign s1_better   = s1_free && (s1_dist >= MIND) && (s1_dist >= best_dist);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            slot_q       <= '0;
            head_x_q     <= '0;
            head_y_q     <= '0;
            tries_left   <= '0;
            scan_x       <= '0;
            scan_y       <= '0;
            s1_valid     <= 1'b0;
            s1_inrange   <= 1'b0;
            s1_x         <= '0;
            s1_y         <= '0;
            s1_dist      <= '0;
            best_x       <= '0;
            best_y       <= '0;
            best_dist    <= '0;
            found        <= 1'b0;
            fruit_x_flat <= '0;
            fruit_y_flat <= '0;
            fruit_valid  <= '0;
            done         <= 1'b0;
            done_slot    <= '0;
            fail         <= 1'b0;
        end else begin
            done       <= 1'b0;
            fail       <= 1'b0;
            s1_valid   <= occ_rd_en;
            s1_inrange <= (state == S_SCAN) || rnd_inrange;
            s1_x       <= issue_x;
            s1_y       <= issue_y;
            s1_dist    <= issue_dist;

            // A refill of the same slot in S_DONE is written later and wins.
            if (eat_valid) begin
                fruit_valid[eat_slot] <= 1'b0;
            end

            unique case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        slot_q     <= req_slot;
                        head_x_q   <= head_x;
                        head_y_q   <= head_y;
                        best_x     <= '0;
                        best_y     <= '0;
                        best_dist  <= '0;
                        found      <= 1'b0;
                        tries_left <= TRIES_C;
                        state      <= S_SAMPLE;
                    end
                end
                S_SAMPLE, S_DRAIN: begin
                    if (s1_better) begin
                        best_x    <= s1_x;
                        best_y    <= s1_y;
                        best_dist <= s1_dist;
                        found     <= 1'b1;
                    end
                    if (state == S_SAMPLE) begin
                        tries_left <= tries_left - 8'd1;
                        if (tries_left == 8'd1) begin
                            state <= S_DRAIN;
                        end
                    end else begin
                        scan_x <= XMIN;
                        scan_y <= YMIN;
                        state  <= (found || s1_better) ? S_DONE : S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (scan_x == XMAX) begin
                        scan_x <= XMIN;
                        scan_y <= scan_y + CY_W'(1);
                    end else begin
                        scan_x <= scan_x + CX_W'(1);
                    end
                    if (scan_last) begin
                        state <= S_SCAN_DRAIN;
                    end
                    if (s1_free) begin
                        best_x <= s1_x;
                        best_y <= s1_y;
                        found  <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_SCAN_DRAIN: begin
                    if (s1_free) begin
                        best_x <= s1_x;
                        best_y <= s1_y;
                        found  <= 1'b1;
                    end
                    state <= S_DONE;
                end
                S_DONE: begin
                    done      <= 1'b1;
                    done_slot <= slot_q;
                    fail      <= !found;
                    if (found) begin
                        fruit_x_flat[int'(slot_q)*CX_W +: CX_W] <= best_x;
                        fruit_y_flat[int'(slot_q)*CY_W +: CY_W] <= best_y;
                        fruit_valid[slot_q] <= 1'b1;
                    end else begin
                        fruit_valid[slot_q] <= 1'b0;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fruit_spawner.sv
// Self-checking bench for fruit_spawner: occupancy RAM model, request
// scoreboard with a behavioural placement model, vector table + sequences.
module tb_fruit_spawner;
    import snake_grid_pkg::*;

    localparam int NF       = 4;
    localparam int TRIES    = 16;
    localparam int MIN_DIST = 3;
    localparam int N_CELLS  = X_SPAN * Y_SPAN;
    localparam int FAIL_LAT = TRIES + N_CELLS + 3;

    logic                 clk = 1'b0;
    logic                 resetn = 1'b0;
    logic                 req_valid = 1'b0;
    logic [1:0]           req_slot = '0;
    logic                 req_ready;
    logic [CX_W-1:0]      head_x = '0;
    logic [CY_W-1:0]      head_y = '0;
    logic                 eat_valid = 1'b0;
    logic [1:0]           eat_slot = '0;
    logic                 occ_rd_en;
    logic [CX_W-1:0]      occ_rd_x;
    logic [CY_W-1:0]      occ_rd_y;
    logic                 occ_rd_data = 1'b0;
    logic [NF*CX_W-1:0]   fruit_x_flat;
    logic [NF*CY_W-1:0]   fruit_y_flat;
    logic [NF-1:0]        fruit_valid;
    logic                 done;
    logic [1:0]           done_slot;
    logic                 fail;

    fruit_spawner #(
        .NUM_FRUITS (NF),
        .TRIES      (TRIES),
        .MIN_DIST   (MIN_DIST)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_slot     (req_slot),
        .req_ready    (req_ready),
        .head_x       (head_x),
        .head_y       (head_y),
        .eat_valid    (eat_valid),
        .eat_slot     (eat_slot),
        .occ_rd_en    (occ_rd_en),
        .occ_rd_x     (occ_rd_x),
        .occ_rd_y     (occ_rd_y),
        .occ_rd_data  (occ_rd_data),
        .fruit_x_flat (fruit_x_flat),
        .fruit_y_flat (fruit_y_flat),
        .fruit_valid  (fruit_valid),
        .done         (done),
        .done_slot    (done_slot),
        .fail         (fail)
    );

    always #5 clk = ~clk;

    bit occ_mem [64][32];

    always @(posedge clk) begin
        if (occ_rd_en) occ_rd_data <= occ_mem[occ_rd_x][occ_rd_y];
    end

    int n_chk = 0;
    int n_fail = 0;

    function automatic void chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    typedef struct {
        int slot;
        int hx;
        int hy;
        int acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   cand_x[$];
    int   cand_y[$];
    int   issue_idx = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    bit   m_valid [NF];
    int   m_x [NF];
    int   m_y [NF];

    int last_fail, last_lat, last_x, last_y;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic bit blocked(input int x, input int y, input int slot);
        for (int i = 0; i < NF; i++)
            if (m_valid[i] && i != slot && m_x[i] == x && m_y[i] == y) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit free_cell(input int x, input int y, input exp_t e);
        return !occ_mem[x][y] && !(x == e.hx && y == e.hy) && !blocked(x, y, e.slot);
    endfunction

    // Farthest legal random candidate (later wins ties), else first free raster cell.
    function automatic void predict(input exp_t e, output bit found,
                                    output int ex, output int ey, output int lat);
        int best;
        int k;
        found = 1'b0; ex = 0; ey = 0; best = -1; lat = FAIL_LAT;
        foreach (cand_x[i]) begin
            int x;
            int y;
            int d;
            x = cand_x[i];
            y = cand_y[i];
            if (x >= X_MIN && x <= X_MAX && y >= Y_MIN && y <= Y_MAX) begin
                d = iabs(x - e.hx) + iabs(y - e.hy);
                if (free_cell(x, y, e) && d >= MIN_DIST && d >= best) begin
                    best = d; ex = x; ey = y; found = 1'b1;
                end
            end
        end
        if (found) begin
            lat = TRIES + 2;
            return;
        end
        k = 0;
        for (int y = Y_MIN; y <= Y_MAX; y++) begin
            for (int x = X_MIN; x <= X_MAX; x++) begin
                if (!found && free_cell(x, y, e)) begin
                    found = 1'b1; ex = x; ey = y; lat = TRIES + 4 + k;
                end
                k++;
            end
        end
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (resetn) begin
            if (eat_valid) m_valid[eat_slot] = 1'b0;
            if (req_valid && req_ready) begin
                sb.push_back('{int'(req_slot), int'(head_x), int'(head_y), cyc});
                cand_x.delete();
                cand_y.delete();
                issue_idx = 0;
            end else if (occ_rd_en) begin
                if (issue_idx < TRIES) begin
                    cand_x.push_back(int'(occ_rd_x));
                    cand_y.push_back(int'(occ_rd_y));
                end
                issue_idx++;
            end
        end
    end

    exp_t h_e;
    bit   h_found;
    int   h_x, h_y, h_lat, h_vec;

    always @(negedge clk) begin
        if (resetn && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                h_e = sb.pop_front();
                predict(h_e, h_found, h_x, h_y, h_lat);
                last_lat  = cyc - h_e.acc_cyc;
                last_fail = int'(fail);
                last_x    = int'(fruit_x_flat[h_e.slot*CX_W +: CX_W]);
                last_y    = int'(fruit_y_flat[h_e.slot*CY_W +: CY_W]);
                chk("done_slot", int'(done_slot), h_e.slot);
                chk("fail_flag", last_fail, int'(!h_found));
                chk("latency", last_lat, h_lat);
                chk("sample_issues", cand_x.size(), TRIES);
                if (h_found) begin
                    chk("fruit_x", last_x, h_x);
                    chk("fruit_y", last_y, h_y);
                    m_x[h_e.slot] = h_x;
                    m_y[h_e.slot] = h_y;
                end
                m_valid[h_e.slot] = h_found;
                h_vec = 0;
                for (int i = 0; i < NF; i++) h_vec |= int'(m_valid[i]) << i;
                chk("fruit_valid", int'(fruit_valid), h_vec);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, int'(req_ready), 1);
        chk({tag, "_fruit_valid"}, int'(fruit_valid), 0);
        chk({tag, "_fruit_x"}, int'(fruit_x_flat), 0);
        chk({tag, "_fruit_y"}, int'(fruit_y_flat), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_fail"}, int'(fail), 0);
        chk({tag, "_occ_rd_en"}, int'(occ_rd_en), 0);
    endtask

    task automatic set_occ(input int mode);
        for (int x = 0; x < 64; x++)
            for (int y = 0; y < 32; y++)
                case (mode)
                    0: occ_mem[x][y] = 1'b0;
                    1: occ_mem[x][y] = !(x == 5 && y == 7);
                    2: occ_mem[x][y] = 1'b1;
                    default: occ_mem[x][y] = ($urandom_range(0, 99) < 30);
                endcase
    endtask

    task automatic eat_all();
        for (int s = 0; s < NF; s++) begin
            @(negedge clk);
            eat_valid = 1'b1;
            eat_slot  = 2'(s);
        end
        @(negedge clk);
        eat_valid = 1'b0;
    endtask

    task automatic do_req(input int slot, input int hx, input int hy);
        @(negedge clk);
        req_valid = 1'b1;
        req_slot  = 2'(slot);
        head_x    = CX_W'(hx);
        head_y    = CY_W'(hy);
        @(negedge clk);
        req_valid = 1'b0;
        head_x    = CX_W'($urandom);
        head_y    = CY_W'($urandom);
    endtask

    task automatic wait_done(input int budget);
        int c0;
        int n;
        c0 = done_cnt;
        n = 0;
        while (done_cnt == c0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == c0) begin
            chk("done_timeout", 0, 1);
            sb.delete();
        end
    endtask

    typedef struct {
        int hx;
        int hy;
        int slot;
        int occ_mode;
        bit pre_clear;
        int exp_fail;
        int exp_x;
        int exp_y;
        int exp_lat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int d;
        vecs[0] = '{10, 10, 0, 0, 1'b0, 0, -1, -1, TRIES + 2};
        vecs[1] = '{30, 20, 1, 1, 1'b1, 0,  5,  7, TRIES + 4 + 6*X_SPAN + 4};
        vecs[2] = '{20, 15, 2, 2, 1'b0, 1, -1, -1, FAIL_LAT};
        vecs[3] = '{ 1,  1, 3, 0, 1'b1, 0, -1, -1, TRIES + 2};
        vecs[4] = '{38, 28, 0, 0, 1'b0, 0, -1, -1, TRIES + 2};
        vecs[5] = '{ 5,  7, 1, 1, 1'b0, 1, -1, -1, FAIL_LAT};

        set_occ(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            set_occ(vecs[i].occ_mode);
            if (vecs[i].pre_clear) eat_all();
            do_req(vecs[i].slot, vecs[i].hx, vecs[i].hy);
            wait_done(FAIL_LAT + 20);
            chk("tbl_fail", last_fail, vecs[i].exp_fail);
            chk("tbl_latency", last_lat, vecs[i].exp_lat);
            if (vecs[i].exp_x >= 0) begin
                chk("tbl_x", last_x, vecs[i].exp_x);
                chk("tbl_y", last_y, vecs[i].exp_y);
            end
            if (vecs[i].exp_fail == 0) begin
                d = iabs(last_x - vecs[i].hx) + iabs(last_y - vecs[i].hy);
                chk("tbl_min_dist", int'(d >= MIN_DIST), 1);
                chk("tbl_in_bounds", int'(last_x >= X_MIN && last_x <= X_MAX
                    && last_y >= Y_MIN && last_y <= Y_MAX), 1);
            end
            chk("tbl_slot_valid", int'(fruit_valid[vecs[i].slot]), int'(vecs[i].exp_fail == 0));
            if (i == 0) chk("first_fruit_valid", int'(fruit_valid), 1);
        end

        set_occ(3);
        eat_all();
        for (int s = 0; s < 3; s++) begin
            do_req(s, $urandom_range(X_MIN, X_MAX), $urandom_range(Y_MIN, Y_MAX));
            wait_done(FAIL_LAT + 20);
        end
        for (int r = 0; r < 200; r++) begin
            repeat ($urandom_range(0, 7)) @(negedge clk);
            do_req(3, $urandom_range(X_MIN, X_MAX), $urandom_range(Y_MIN, Y_MAX));
            wait_done(FAIL_LAT + 20);
            if (!last_fail) begin
                chk("multi_not_body", int'(occ_mem[last_x][last_y]), 0);
                for (int j = 0; j < 3; j++)
                    if (m_valid[j])
                        chk("multi_distinct", int'(last_x == m_x[j] && last_y == m_y[j]), 0);
            end
        end

        set_occ(0);
        @(negedge clk);
        req_valid = 1'b1;
        req_slot  = 2'd1;
        head_x    = CX_W'(12);
        head_y    = CY_W'(9);
        c0 = done_cnt;
        @(negedge clk);
        req_slot = 2'd2;
        head_x   = CX_W'(3);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("busy_not_ready", int'(req_ready), 0);
        end
        req_valid = 1'b0;
        repeat (14) @(negedge clk);
        eat_valid = 1'b1;
        eat_slot  = 2'd1;
        @(negedge clk);
        eat_valid = 1'b0;
        wait_done(100);
        chk("eat_on_done_valid", int'(fruit_valid[1]), 1);
        repeat (40) @(posedge clk);
        chk("busy_req_ignored", done_cnt - c0, 1);

        do_req(0, 20, 10);
        repeat (4) @(negedge clk);
        resetn = 1'b0;
        sb.delete();
        for (int i = 0; i < NF; i++) m_valid[i] = 1'b0;
        c0 = done_cnt;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midreset");
        resetn = 1'b1;
        repeat (40) @(posedge clk);
        chk("no_done_after_reset", done_cnt - c0, 0);

        do_req(2, 10, 10);
        wait_done(FAIL_LAT + 20);
        chk("recover_valid", int'(fruit_valid), 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
